// File: rtl/gol_frame_reader.sv
// rtl/gol_frame_reader.sv - Game of Life frame read-out engine: grid memory words to a pixel stream
module gol_frame_reader #(
  parameter int          WIDTH       = 640,
  parameter int          HEIGHT      = 480,
  parameter int          WORD_W      = 32,
  parameter logic [23:0] ALIVE_COLOR = 24'hFFFFFF,
  parameter logic [23:0] DEAD_COLOR  = 24'h000000,
  parameter int          ADDR_W      = $clog2(HEIGHT*WIDTH/WORD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [23:0]       pix_data,
  output logic              pix_sof,
  output logic              pix_eol
);

  localparam int TOTAL_WORDS = HEIGHT*WIDTH/WORD_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int BW = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL_WORDS);
  localparam logic [XW-1:0]    X_LAST   = XW'(WIDTH-1);
  localparam logic [YW-1:0]    Y_LAST   = YW'(HEIGHT-1);
  localparam logic [BW-1:0]    B_LAST   = BW'(WORD_W-1);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;
  state_t state, state_next;

  // pix_valid doubles as "active shift word present"; pend_* is the look-ahead word.
  logic [CNT_W-1:0]  rd_cnt, rd_cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic              rd_ret;
  logic [1:0]        slots, slots_n, slots_after;
  logic [WORD_W-1:0] act_word, act_word_n, pend_word, pend_word_n;
  logic              pend_valid, pend_valid_n, pix_valid_n;
  logic [BW-1:0]     bit_idx, bit_n;
  logic [XW-1:0]     x, x_n;
  logic [YW-1:0]     y, y_n;
  logic [23:0]       pix_data_n;
  logic              pix_sof_n, pix_eol_n;
  logic              handshake, word_done, last_pix, start_go, issue;

  assign handshake   = pix_valid && pix_ready;
  assign word_done   = handshake && (bit_idx == B_LAST);
  assign last_pix    = handshake && (x == X_LAST) && (y == Y_LAST);
  assign start_go    = (state == IDLE) && start;
  // slots = buffered words + reads in flight, counted after this cycle's consumption
  assign slots_after = slots - {1'b0, word_done};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: frame request, last pixel accepted, one-cycle finish
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = STREAM;
      STREAM:  if (last_pix) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath next values: read issue, word buffer, shift position and raster counters
  always_comb begin
    issue        = 1'b0;
    addr_n       = mem_addr;
    rd_cnt_n     = rd_cnt;
    slots_n      = slots;
    act_word_n   = act_word;
    pix_valid_n  = pix_valid;
    pend_word_n  = pend_word;
    pend_valid_n = pend_valid;
    bit_n        = bit_idx;
    x_n          = x;
    y_n          = y;
    if (start_go) begin
      issue        = 1'b1;
      addr_n       = '0;
      rd_cnt_n     = CNT_W'(1);
      slots_n      = 2'd1;
      pix_valid_n  = 1'b0;
      pend_valid_n = 1'b0;
      bit_n        = '0;
      x_n          = '0;
      y_n          = '0;
    end else if (state == STREAM) begin
      issue = (slots_after < 2'd2) && (rd_cnt < LAST_CNT);
      if (issue) begin
        addr_n   = rd_cnt[ADDR_W-1:0];
        rd_cnt_n = rd_cnt + CNT_W'(1);
      end
      slots_n = slots_after + {1'b0, issue};
      if (handshake) begin
        bit_n = word_done ? '0 : bit_idx + BW'(1);
        if (x == X_LAST) begin
          x_n = '0;
          y_n = (y == Y_LAST) ? '0 : y + YW'(1);
        end else begin
          x_n = x + XW'(1);
        end
      end
      // Pending word takes over in the same cycle the last bit is accepted
      if (word_done) begin
        act_word_n   = pend_word;
        pix_valid_n  = pend_valid;
        pend_valid_n = 1'b0;
      end
      if (rd_ret) begin
        if (!pix_valid_n) begin
          act_word_n  = mem_rdata;
          pix_valid_n = 1'b1;
        end else begin
          pend_word_n  = mem_rdata;
          pend_valid_n = 1'b1;
        end
      end
    end
    pix_data_n = pix_valid_n ? (act_word_n[bit_n] ? ALIVE_COLOR : DEAD_COLOR) : 24'h0;
    pix_sof_n  = pix_valid_n && (x_n == '0) && (y_n == '0);
    pix_eol_n  = pix_valid_n && (x_n == X_LAST);
  end

  // Register every output and datapath value; reset drops any in-flight read return
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      rd_cnt     <= '0;
      rd_ret     <= 1'b0;
      slots      <= '0;
      act_word   <= '0;
      pend_word  <= '0;
      pend_valid <= 1'b0;
      bit_idx    <= '0;
      x          <= '0;
      y          <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
    end else begin
      busy       <= (state_next == STREAM);
      done       <= (state_next == FINISH);
      mem_rd_en  <= issue;
      mem_addr   <= addr_n;
      rd_cnt     <= rd_cnt_n;
      rd_ret     <= mem_rd_en;
      slots      <= slots_n;
      act_word   <= act_word_n;
      pend_word  <= pend_word_n;
      pend_valid <= pend_valid_n;
      bit_idx    <= bit_n;
      x          <= x_n;
      y          <= y_n;
      pix_valid  <= pix_valid_n;
      pix_data   <= pix_data_n;
      pix_sof    <= pix_sof_n;
      pix_eol    <= pix_eol_n;
    end
  end

endmodule
